// File: rtl/regfile_pkg.sv
// Shared types and constants for the ARM64 register-file write-back path.
package regfile_pkg;

    localparam int         WB_DEPTH = 4;
    localparam logic [4:0] XZR      = 5'd31;

    typedef struct packed {
        logic [4:0]  wa;
        logic [63:0] wd;
    } wb_entry_t;

endpackage

// File: rtl/wb_lookup.sv
// Forwarding lookup: newest pending entry whose destination matches ra_i.
module wb_lookup
    import regfile_pkg::*;
#(
    parameter  int DEPTH  = WB_DEPTH,
    parameter  int DATA_W = 64,
    parameter  int ADDR_W = 5,
    localparam int PW     = $clog2(DEPTH),
    localparam int CW     = PW + 1
) (
    input  logic [ADDR_W-1:0] ra_i,
    input  logic [ADDR_W-1:0] ent_wa_i [DEPTH],
    input  logic [DATA_W-1:0] ent_wd_i [DEPTH],
    input  logic [PW-1:0]     head_i,
    input  logic [CW-1:0]     count_i,
    output logic              hit_o,
    output logic [DATA_W-1:0] fwd_o
);

    // Walk oldest to newest so the last match seen is the newest one.
    always_comb begin
        hit_o = 1'b0;
        fwd_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] idx;
            idx = head_i + PW'(i);
            if ((CW'(i) < count_i) && (ent_wa_i[idx] == ra_i)) begin
                hit_o = 1'b1;
                fwd_o = ent_wd_i[idx];
            end
        end
        if (ra_i == ADDR_W'(XZR)) begin
            hit_o = 1'b0;
            fwd_o = '0;
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back queue: two results in per cycle, one drained per cycle into the
// register file's single write port, with forwarding to the decode read ports.
module regfile_wb_queue
    import regfile_pkg::*;
#(
    parameter  int DEPTH  = WB_DEPTH,
    parameter  int DATA_W = 64,
    parameter  int ADDR_W = 5,
    localparam int PW     = $clog2(DEPTH),
    localparam int CW     = PW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid0,
    input  logic [ADDR_W-1:0] in_wa0,
    input  logic [DATA_W-1:0] in_wd0,
    input  logic              in_valid1,
    input  logic [ADDR_W-1:0] in_wa1,
    input  logic [DATA_W-1:0] in_wd1,
    output logic              in_ready,
    output logic              we3,
    output logic [ADDR_W-1:0] wa3,
    output logic [DATA_W-1:0] wd3,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic              hit1,
    output logic              hit2,
    output logic [DATA_W-1:0] fwd1,
    output logic [DATA_W-1:0] fwd2,
    output logic [CW-1:0]     count
);

    logic [ADDR_W-1:0] mem_wa_q [DEPTH];
    logic [DATA_W-1:0] mem_wd_q [DEPTH];
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d, tail1;
    logic [CW-1:0]     count_q, count_d;
    logic              pop, push0, push1;

    // Readiness ignores this cycle's pop so upstream sees a stable decision.
    always_comb begin
        pop      = (count_q != '0);
        in_ready = (CW'(DEPTH) - count_q) >= CW'(2);
        push0    = in_ready && in_valid0 && (in_wa0 != ADDR_W'(XZR));
        push1    = in_ready && in_valid1 && (in_wa1 != ADDR_W'(XZR));
        tail1    = tail_q + PW'(push0);
        tail_d   = tail1 + PW'(push1);
        head_d   = head_q + PW'(pop);
        count_d  = count_q + CW'(push0) + CW'(push1) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload needs no reset: occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (push0) begin
            mem_wa_q[tail_q] <= in_wa0;
            mem_wd_q[tail_q] <= in_wd0;
        end
        if (push1) begin
            mem_wa_q[tail1] <= in_wa1;
            mem_wd_q[tail1] <= in_wd1;
        end
    end

    assign we3   = pop;
    assign wa3   = pop ? mem_wa_q[head_q] : '0;
    assign wd3   = pop ? mem_wd_q[head_q] : '0;
    assign count = count_q;

    wb_lookup #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_lookup1 (
        .ra_i(ra1), .ent_wa_i(mem_wa_q), .ent_wd_i(mem_wd_q),
        .head_i(head_q), .count_i(count_q), .hit_o(hit1), .fwd_o(fwd1)
    );

    wb_lookup #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_lookup2 (
        .ra_i(ra2), .ent_wa_i(mem_wa_q), .ent_wd_i(mem_wd_q),
        .head_i(head_q), .count_i(count_q), .hit_o(hit2), .fwd_o(fwd2)
    );

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Scoreboard bench: expected register-file writes are queued at issue and
// checked by a negedge monitor; state and lookup checked directly.
module tb_regfile_wb_queue;

    typedef struct {
        logic [4:0]  wa;
        logic [63:0] wd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid0 = 1'b0, in_valid1 = 1'b0;
    logic [4:0]  in_wa0 = '0, in_wa1 = '0, ra1 = '0, ra2 = '0;
    logic [63:0] in_wd0 = '0, in_wd1 = '0;
    logic        in_ready, we3, hit1, hit2;
    logic [4:0]  wa3;
    logic [63:0] wd3, fwd1, fwd2;
    logic [2:0]  count;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    regfile_wb_queue dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid0(in_valid0), .in_wa0(in_wa0), .in_wd0(in_wd0),
        .in_valid1(in_valid1), .in_wa1(in_wa1), .in_wd1(in_wd1),
        .in_ready(in_ready), .we3(we3), .wa3(wa3), .wd3(wd3),
        .ra1(ra1), .ra2(ra2), .hit1(hit1), .hit2(hit2),
        .fwd1(fwd1), .fwd2(fwd2), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: every write-port beat must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && we3) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got wa3=%0d wd3=%0h expected none", wa3, wd3);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wa3", 64'(wa3), 64'(e.wa));
                check("wd3", wd3, e.wd);
            end
        end
    end

    // Drive one cycle of stimulus; acc is the hand-computed acceptance.
    task automatic push(input logic v0, input logic [4:0] a0, input logic [63:0] d0,
                        input logic v1, input logic [4:0] a1, input logic [63:0] d1,
                        input bit acc);
        in_valid0 = v0; in_wa0 = a0; in_wd0 = d0;
        in_valid1 = v1; in_wa1 = a1; in_wd1 = d1;
        if (acc && v0 && a0 != 5'd31) exp_q.push_back('{a0, d0});
        if (acc && v1 && a1 != 5'd31) exp_q.push_back('{a1, d1});
        @(posedge clk); #1;
        in_valid0 = 1'b0; in_valid1 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        #3;
        check("reset_count", 64'(count), 64'd0);
        check("reset_we3", 64'(we3), 64'd0);
        check("reset_ready", 64'(in_ready), 64'd1);
        check("reset_hit1", 64'(hit1), 64'd0);
        check("reset_fwd1", fwd1, 64'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Single push into empty queue
        ra1 = 5'd4;
        push(1, 5'd4, 64'd35, 0, 5'd0, 64'd0, 1);
        check("single_we3", 64'(we3), 64'd1);
        check("single_wa3", 64'(wa3), 64'd4);
        check("single_wd3", wd3, 64'd35);
        check("single_hit1", 64'(hit1), 64'd1);
        check("single_fwd1", fwd1, 64'd35);
        check("single_count", 64'(count), 64'd1);
        idle(1);
        check("single_we3_after", 64'(we3), 64'd0);
        check("single_count_after", 64'(count), 64'd0);
        check("single_hit1_after", 64'(hit1), 64'd0);

        // Same-destination pair: newest wins in lookup, oldest drains first
        ra1 = 5'd7;
        push(1, 5'd7, 64'd10, 1, 5'd7, 64'd20, 1);
        check("pair_count", 64'(count), 64'd2);
        check("pair_hit1", 64'(hit1), 64'd1);
        check("pair_fwd1", fwd1, 64'd20);
        idle(1);
        check("pair_fwd1_tail", fwd1, 64'd20);
        idle(2);

        // XZR in slot 0 is dropped; slot 1 takes its place
        ra1 = 5'd5; ra2 = 5'd31;
        push(1, 5'd31, 64'd77, 1, 5'd5, 64'd9, 1);
        check("xzr_count", 64'(count), 64'd1);
        check("xzr_wa3", 64'(wa3), 64'd5);
        check("xzr_hit1", 64'(hit1), 64'd1);
        check("xzr_fwd1", fwd1, 64'd9);
        check("xzr_hit2", 64'(hit2), 64'd0);
        check("xzr_fwd2", fwd2, 64'd0);
        idle(2);

        // Fill to 3, ignored push while not ready, then wrap
        push(1, 5'd1, 64'd100, 1, 5'd2, 64'd200, 1);
        check("fill_count2", 64'(count), 64'd2);
        check("fill_ready2", 64'(in_ready), 64'd1);
        push(1, 5'd3, 64'd300, 1, 5'd6, 64'd600, 1);
        check("fill_count3", 64'(count), 64'd3);
        check("fill_ready3", 64'(in_ready), 64'd0);
        push(1, 5'd8, 64'd800, 1, 5'd9, 64'd900, 0);
        check("stall_count", 64'(count), 64'd2);
        check("stall_ready", 64'(in_ready), 64'd1);
        ra1 = 5'd8;
        check("stall_hit1", 64'(hit1), 64'd0);
        push(1, 5'd10, 64'd1000, 1, 5'd11, 64'd1100, 1);
        check("wrap_count", 64'(count), 64'd3);
        ra1 = 5'd11; ra2 = 5'd6;
        #1;
        check("wrap_fwd1", fwd1, 64'd1100);
        check("wrap_fwd2", fwd2, 64'd600);
        ra2 = 5'd1;
        #1;
        check("wrap_hit2_drained", 64'(hit2), 64'd0);
        idle(4);
        check("wrap_empty", 64'(count), 64'd0);

        // Sustained 1-in/1-out
        for (int i = 0; i < 20; i++) begin
            push(1, 5'((i % 30) + 1), 64'(i * 1000 + 7), 0, 5'd0, 64'd0, 1);
            check("steady_count", 64'(count), 64'd1);
        end
        idle(2);
        check("steady_empty", 64'(count), 64'd0);

        // Asynchronous reset with three entries pending
        push(1, 5'd13, 64'd1, 1, 5'd14, 64'd2, 1);
        push(1, 5'd15, 64'd3, 1, 5'd16, 64'd4, 1);
        check("mid_count3", 64'(count), 64'd3);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("mid_rst_count", 64'(count), 64'd0);
        check("mid_rst_we3", 64'(we3), 64'd0);
        check("mid_rst_ready", 64'(in_ready), 64'd1);
        idle(1);
        rst_n = 1'b1;
        idle(3);
        check("post_rst_count", 64'(count), 64'd0);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
